// File: rtl/scaler_linear_v.sv
// Vertical 2-tap linear downscaler: blends the buffered previous line with the
// live line, four register stages from de_i to de_o, sync format preserved.
module scaler_linear_v #(
    parameter int PIXEL_STEP  = 4096,
    parameter int PIXEL_WIDTH = 12,
    parameter int LINE_MAX    = 4096
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            scale_step,
    input  logic [PIXEL_WIDTH-1:0] di_i,
    input  logic                   de_i,
    input  logic                   hs_i,
    input  logic                   vs_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   ovf_o
);

    localparam int LOG       = $clog2(PIXEL_STEP);
    localparam int COE_WIDTH = LOG + 1;
    localparam int PW        = PIXEL_WIDTH + COE_WIDTH;
    localparam int SW        = PW + 1;
    localparam int AW        = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;

    localparam logic [15:0]          STEP_ONE = 16'(PIXEL_STEP);
    localparam logic [23:0]          Y_ONE    = 24'(PIXEL_STEP);
    localparam logic [COE_WIDTH-1:0] COE_ONE  = COE_WIDTH'(PIXEL_STEP);
    localparam logic [SW-1:0]        HALF     = SW'(PIXEL_STEP / 2);
    localparam logic [SW-1:0]        PIX_MAX  = SW'((1 << PIXEL_WIDTH) - 1);
    localparam logic [AW-1:0]        X_LAST   = AW'(LINE_MAX - 1);

    function automatic logic [PIXEL_WIDTH-1:0] round_sat(input logic [SW-1:0] s);
        logic [SW-1:0] q;
        q = (s + HALF) >> LOG;
        if (q > PIX_MAX)
            return '1;
        return q[PIXEL_WIDTH-1:0];
    endfunction

    // Frame/line control state
    logic                   synced;
    logic [15:0]            step;
    logic [23:0]            y_i, y_o;
    logic                   first_line;
    logic                   emit_line;
    logic [COE_WIDTH-1:0]   dy;
    logic [AW-1:0]          x;
    logic                   over;

    logic                   frame_start, active, line_start;
    logic [15:0]            step_cur;
    logic [23:0]            y_i_cur, y_o_cur;
    logic                   first_cur, emit_cur, over_cur;
    logic [COE_WIDTH-1:0]   dy_cur;
    logic [AW-1:0]          addr;

    // Frame-start updates are folded in before the line-start decision.
    always_comb begin
        frame_start = de_i & hs_i & vs_i;
        active      = de_i & (synced | frame_start);
        line_start  = active & hs_i;
        step_cur    = step;
        y_i_cur     = y_i;
        y_o_cur     = y_o;
        first_cur   = first_line;
        emit_cur    = emit_line;
        dy_cur      = dy;
        addr        = x;
        over_cur    = over;
        if (frame_start) begin
            step_cur  = (scale_step < STEP_ONE) ? STEP_ONE : scale_step;
            y_i_cur   = '0;
            y_o_cur   = '0;
            first_cur = 1'b1;
        end else if (line_start) begin
            first_cur = 1'b0;
        end
        if (line_start) begin
            emit_cur = (y_o_cur <= y_i_cur);
            if (emit_cur)
                dy_cur = COE_WIDTH'(y_i_cur - y_o_cur);
            addr     = '0;
            over_cur = 1'b0;
        end
    end

    logic                   vld_p0, vld_p1, vld_p2;
    logic                   hs_p0, hs_p1, hs_p2;
    logic                   vs_p0, vs_p1, vs_p2;
    logic [PIXEL_WIDTH-1:0] rd_p0, di_p0;
    logic                   zero_p0;
    logic [COE_WIDTH-1:0]   dy_p0;
    logic [PW-1:0]          prod_prev_p1, prod_cur_p1;
    logic [SW-1:0]          sum_p2;

    logic [PIXEL_WIDTH-1:0] ram [LINE_MAX];
    logic [PIXEL_WIDTH-1:0] prev_sel;
    logic [COE_WIDTH-1:0]   coe_cur;

    assign prev_sel = zero_p0 ? '0 : rd_p0;
    assign coe_cur  = COE_ONE - dy_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            synced     <= 1'b0;
            step       <= STEP_ONE;
            y_i        <= '0;
            y_o        <= '0;
            first_line <= 1'b0;
            emit_line  <= 1'b0;
            dy         <= '0;
            x          <= '0;
            over       <= 1'b0;
            ovf_o      <= 1'b0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            vld_p2     <= 1'b0;
            hs_p0      <= 1'b0;
            hs_p1      <= 1'b0;
            hs_p2      <= 1'b0;
            vs_p0      <= 1'b0;
            vs_p1      <= 1'b0;
            vs_p2      <= 1'b0;
            de_o       <= 1'b0;
            hs_o       <= 1'b0;
            vs_o       <= 1'b0;
            do_o       <= '0;
        end else begin
            if (active) begin
                synced     <= 1'b1;
                step       <= step_cur;
                first_line <= first_cur;
                emit_line  <= emit_cur;
                dy         <= dy_cur;
                if (line_start) begin
                    y_i <= y_i_cur + Y_ONE;
                    if (emit_cur)
                        y_o <= y_o_cur + 24'(step_cur);
                end
                if (frame_start)
                    ovf_o <= 1'b0;
                over <= over_cur;
                if (over_cur)
                    ovf_o <= 1'b1;
                else if (addr == X_LAST)
                    over <= 1'b1;
                else
                    x <= addr + 1'b1;
            end
            // Stage 1 control: only pixels of emitted lines travel down the pipe
            vld_p0 <= active & emit_cur;
            hs_p0  <= line_start;
            vs_p0  <= frame_start;
            vld_p1 <= vld_p0;
            hs_p1  <= hs_p0;
            vs_p1  <= vs_p0;
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
            vs_p2  <= vs_p1;
            // Stage 4: output register, data holds between valid pixels
            de_o   <= vld_p2;
            hs_o   <= vld_p2 & hs_p2;
            vs_o   <= vld_p2 & vs_p2;
            if (vld_p2)
                do_o <= round_sat(sum_p2);
        end
    end

    // Stage 1: read-first line buffer; overflowed pixels bypass the RAM entirely
    always_ff @(posedge clk) begin
        if (active && !over_cur)
            ram[addr] <= di_i;
        rd_p0 <= ram[addr];
    end

    always_ff @(posedge clk) begin
        di_p0        <= di_i;
        zero_p0      <= first_cur | over_cur;
        dy_p0        <= dy_cur;
        // Stage 2: weight both taps
        prod_prev_p1 <= PW'(dy_p0) * PW'(prev_sel);
        prod_cur_p1  <= PW'(coe_cur) * PW'(di_p0);
        // Stage 3: blend
        sum_p2       <= SW'(prod_prev_p1) + SW'(prod_cur_p1);
    end

endmodule

// File: tb/tb_scaler_linear_v.sv
// Scoreboard bench for scaler_linear_v: a per-pixel model pushes expected
// outputs as stimulus is driven; a monitor pops and compares at each de_o.
module tb_scaler_linear_v;

    localparam int LM = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] scale_step;
    logic [11:0] di_i;
    logic        de_i, hs_i, vs_i;
    logic [11:0] do_o;
    logic        de_o, hs_o, vs_o, ovf_o;

    always #5 clk = ~clk;

    scaler_linear_v #(
        .PIXEL_STEP (4096),
        .PIXEL_WIDTH(12),
        .LINE_MAX   (LM)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scale_step(scale_step),
        .di_i      (di_i),
        .de_i      (de_i),
        .hs_i      (hs_i),
        .vs_i      (vs_i),
        .do_o      (do_o),
        .de_o      (de_o),
        .hs_o      (hs_o),
        .vs_o      (vs_o),
        .ovf_o     (ovf_o)
    );

    typedef struct {
        int d;
        bit hs;
        bit vs;
        int cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_do = 0;
    int   img [0:7][0:9];

    // model state
    bit   m_synced = 0, m_first = 0, m_emit = 0, m_ovf = 0;
    int   m_step = 4096, m_yi = 0, m_yo = 0, m_dy = 0, m_x = 0;
    int   mbuf [0:LM-1];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk_val(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            last_do = 0;
        end else begin
            if (!de_o) begin
                chk_val("hold_do", int'(do_o), last_do);
                chk_val("sync_without_de", int'(hs_o | vs_o), 0);
            end else if (sb_q.size() == 0) begin
                chk_val("unexpected_de", int'(de_o), 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk_val("do", int'(do_o), mon_e.d);
                chk_val("hs", int'(hs_o), int'(mon_e.hs));
                chk_val("vs", int'(vs_o), int'(mon_e.vs));
                chk_val("latency", cyc - mon_e.cyc, 4);
            end
            last_do = int'(do_o);
        end
    end

    task automatic px(input int d, input bit h, input bit v, input int gap);
        bit   fs;
        int   prev, e;
        exp_t ent;
        fs = h && v;
        if (fs) begin
            m_synced = 1;
            m_step   = (int'(scale_step) < 4096) ? 4096 : int'(scale_step);
            m_yi     = 0;
            m_yo     = 0;
            m_first  = 1;
            m_ovf    = 0;
        end
        if (m_synced) begin
            if (h) begin
                if (!fs) m_first = 0;
                m_emit = (m_yo <= m_yi);
                if (m_emit) begin
                    m_dy = m_yi - m_yo;
                    m_yo += m_step;
                end
                m_x = 0;
                m_yi += 4096;
            end
            prev = (m_x < LM && !m_first) ? mbuf[m_x] : 0;
            if (m_x < LM) mbuf[m_x] = d;
            else          m_ovf = 1;
            m_x++;
            if (m_emit) begin
                e = (m_dy * prev + (4096 - m_dy) * d + 2048) >> 12;
                if (e > 4095) e = 4095;
                ent.d = e; ent.hs = h; ent.vs = fs; ent.cyc = cyc;
                sb_q.push_back(ent);
            end
        end
        di_i = 12'(d); de_i = 1'b1; hs_i = h; vs_i = v;
        @(negedge clk);
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        if (m_synced) chk_val("ovf", int'(ovf_o), int'(m_ovf));
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_frame(input int nl, input int np, input int gap,
                              input int chg_line, input int chg_val);
        for (int l = 0; l < nl; l++) begin
            if (l == chg_line) scale_step = 16'(chg_val);
            for (int p = 0; p < np; p++)
                px(img[l][p], p == 0, (l == 0) && (p == 0), gap);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic drain();
        repeat (8) @(negedge clk);
        chk_val("sb_empty", sb_q.size(), 0);
    endtask

    task automatic fill_lines(input int v0, input int v1, input int v2,
                              input int v3, input int v4, input int v5);
        for (int p = 0; p < 10; p++) begin
            img[0][p] = v0; img[1][p] = v1; img[2][p] = v2;
            img[3][p] = v3; img[4][p] = v4; img[5][p] = v5;
        end
    endtask

    task automatic fill_random();
        for (int l = 0; l < 8; l++)
            for (int p = 0; p < 10; p++)
                img[l][p] = int'($urandom_range(0, 4095));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired (checks=%0d)", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; scale_step = 16'd4096; di_i = '0;
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) @(negedge clk);
        chk_val("rst_de", int'(de_o), 0);
        chk_val("rst_do", int'(do_o), 0);
        chk_val("rst_hs", int'(hs_o), 0);
        chk_val("rst_vs", int'(vs_o), 0);
        chk_val("rst_ovf", int'(ovf_o), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // input before the first frame start is ignored
        for (int p = 0; p < 4; p++) px(900 + p, p == 0, 1'b0, 0);
        drain();

        // 1:1 pass-through
        scale_step = 16'd4096;
        fill_lines(0, 100, 200, 300, 0, 0);
        send_frame(4, 8, 0, -1, 0);
        drain();

        // 2:1
        scale_step = 16'd8192;
        fill_lines(0, 100, 200, 300, 400, 500);
        send_frame(6, 8, 0, -1, 0);
        drain();

        // 1.5:1
        scale_step = 16'd6144;
        fill_lines(0, 100, 200, 300, 0, 0);
        send_frame(4, 8, 0, -1, 0);
        drain();

        // rounding and saturation at dy=2048, stale RAM on line 0
        scale_step = 16'd6144;
        fill_lines(7, 1, 2, 50, 0, 0);
        for (int p = 1; p < 8; p += 2) begin
            img[1][p] = 4095; img[2][p] = 4095;
        end
        send_frame(4, 8, 0, -1, 0);
        drain();

        // scale_step = 0 acts as 1:1
        scale_step = 16'd0;
        fill_random();
        send_frame(4, 8, 0, -1, 0);
        drain();

        // mid-frame step change takes effect on the next frame only
        scale_step = 16'd4096;
        fill_random();
        send_frame(4, 8, 0, 2, 8192);
        fill_random();
        send_frame(4, 8, 0, -1, 0);
        drain();

        // sparse input, one pixel per three cycles
        scale_step = 16'd6144;
        fill_random();
        send_frame(5, 8, 2, -1, 0);
        drain();

        // reset in the middle of a line
        scale_step = 16'd4096;
        for (int p = 0; p < 5; p++) px(500 + p, p == 0, p == 0, 0);
        rst_n = 1'b0;
        #1;
        chk_val("midrst_de", int'(de_o), 0);
        chk_val("midrst_do", int'(do_o), 0);
        chk_val("midrst_hs", int'(hs_o), 0);
        chk_val("midrst_vs", int'(vs_o), 0);
        sb_q.delete();
        m_synced = 0;
        m_emit = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 8; p++) px(1000 + p, p == 0, 1'b0, 0);
        drain();
        fill_lines(10, 20, 30, 40, 0, 0);
        send_frame(2, 8, 0, -1, 0);
        drain();

        // overflow: 10-pixel lines into an 8-entry buffer, then a clean frame
        scale_step = 16'd6144;
        fill_random();
        send_frame(3, 10, 0, -1, 0);
        chk_val("ovf_set", int'(ovf_o), 1);
        fill_lines(1, 2, 3, 4, 0, 0);
        send_frame(2, 8, 0, -1, 0);
        chk_val("ovf_cleared", int'(ovf_o), 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scaler_linear_v.md
Name: scaler_linear_v

Overview:
- Vertical linear (2-tap) downscaler that sits directly downstream of the horizontal scaler.
- Consumes its sparse pixel stream: de_i pulses per pixel, hs_i on the first pixel of a line, vs_i on the first pixel of a frame.
- Keeps one line buffer and blends the buffered previous line with the live line to produce vertically scaled lines in the same sync format.
- Supports scale ratios from 1.0 down (scale_step >= PIXEL_STEP).

Parameters:
- PIXEL_STEP, 4096, fixed-point 1.0; power of two; LOG = log2(PIXEL_STEP).
- PIXEL_WIDTH, 12, pixel bits.
- LINE_MAX, 4096, line buffer depth in pixels.
- COE_WIDTH, LOG+1 (derived localparam, not overridable), coefficient bits; range 0..PIXEL_STEP.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- scale_step, input, 16, unsigned fixed point; PIXEL_STEP = 1.0.
- di_i, input, PIXEL_WIDTH, pixel data.
- de_i, input, 1, pixel valid (may be sparse).
- hs_i, input, 1, first pixel of line; qualified by de_i.
- vs_i, input, 1, first pixel of frame; qualified by de_i.
- do_o, output, PIXEL_WIDTH, scaled pixel.
- de_o, output, 1, output pixel valid.
- hs_o, output, 1, first pixel of output line.
- vs_o, output, 1, first pixel of output frame.
- ovf_o, output, 1, sticky: a line exceeded LINE_MAX.

Behaviour:
- Reset (async, rst_n=0): do_o=0, de_o=0, hs_o=0, vs_o=0, ovf_o=0; counters=0; synced=0. Line buffer contents are not reset.
- Sync: until the first de_i&hs_i&vs_i after reset (synced=0), all input is ignored and no output is produced.
- Frame start (de_i&hs_i&vs_i):
  - Latch step = scale_step; if scale_step < PIXEL_STEP (including 0), step = PIXEL_STEP.
  - y_i=0, y_o=0; ovf_o cleared; first_line=1.
  - scale_step changes mid-frame have no effect until the next frame start.
- Line start (de_i&hs_i), evaluated after any frame-start update:
  - emit = (y_o <= y_i).
  - If emit: dy = y_i - y_o (< PIXEL_STEP by construction), latched for the whole line; y_o += step.
  - x=0. y_i += PIXEL_STEP, taking effect for the next line.
  - y_i and y_o are 24-bit unsigned and reset every frame.
- Per pixel (de_i), at address x:
  - Read-first: prev = RAM[x]; RAM[x] <= di_i; x++.
  - prev is forced to 0 on the first line of a frame.
- Overflow:
  - x saturates at LINE_MAX-1. Pixels at x >= LINE_MAX are neither written nor read and are output with prev=0.
  - ovf_o set on the first such pixel; stays set until the next frame start.
- Arithmetic:
  - coe_prev = dy, coe_cur = PIXEL_STEP - dy, both COE_WIDTH bits.
  - sum = coe_prev*prev + coe_cur*di + PIXEL_STEP/2 (width PIXEL_WIDTH+COE_WIDTH+1).
  - do_o = sum >> LOG, saturated to 2^PIXEL_WIDTH-1.
- Pipeline: fixed 4-cycle latency from de_i to de_o.
  - Stage 1: RAM read + register di.
  - Stage 2: multiply.
  - Stage 3: sum.
  - Stage 4: output register.
- Output sync:
  - de_o pulses only for pixels of emitted lines.
  - hs_o coincides with the first pixel of an emitted line.
  - vs_o coincides with the first pixel of frame line 0 (always emitted, dy=0).
  - hs_o/vs_o never assert without de_o.
  - do_o holds its last value when de_o=0.
- Non-emitted lines are still written to the buffer.
- Back-to-back pixels and arbitrary gaps between de_i pulses are both legal; no backpressure.
- Reset mid-line: pipeline flushed, outputs 0 immediately; resynchronises at the next frame start.

Test Plan:
- 1:1 pass-through. scale_step=4096; 4 lines × 8 px; line k value = 100k. Required:
  - identical lines out, de_o 4 cycles after de_i;
  - hs_o on pixel 0 of each line;
  - vs_o only on line 0 pixel 0.
- 2:1. scale_step=8192; 6 lines of values 0,100..500. Required:
  - output lines 0, 200, 400 (dy=0);
  - no de_o during input lines 1, 3, 5.
- 1.5:1. scale_step=6144; lines 0,100,200,300. Required outputs:
  - line 0 → 0;
  - during line 2 (dy=2048) → 150;
  - during line 3 (y_o=12288, dy=0) → 300.
- Rounding/saturation at dy=2048:
  - prev=1, cur=2 → 2;
  - prev=4095, cur=4095 → 4095;
  - first line of frame with stale RAM → prev ignored.
- Robustness:
  - scale_step=0 behaves as 1:1;
  - scale_step switched 4096→8192 mid-frame only affects the next frame;
  - sparse de_i (1 pixel per 3 cycles) gives identical data.
- Reset and overflow:
  - rst_n low mid-line → outputs 0 at once, nothing emitted until the next vs_i;
  - LINE_MAX=8 with a 10-pixel line → ovf_o=1 from pixel 8, cleared at the next frame start.
